// File: rtl/hvac_sequencer.sv
// Heating/cooling plant sequencer: mutually exclusive heater/AC drive with
// minimum run time, dead-time between runs and window-open lockout.
module hvac_sequencer #(
  parameter int TEMP_W        = 8,
  parameter int HYST          = 2,
  parameter int MIN_ON_CYC    = 4,
  parameter int DEAD_CYC      = 3,
  parameter int PRES_HOLD_CYC = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic              presence,
  input  logic              window,
  input  logic              cool_req,
  output logic              heat_en,
  output logic              cool_en,
  output logic              lockout,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAT = 3'd1,
    S_COOL = 3'd2,
    S_DEAD = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  localparam int TMAX = (MIN_ON_CYC > DEAD_CYC) ? MIN_ON_CYC : DEAD_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(PRES_HOLD_CYC + 1);

  localparam logic [TW-1:0]     RUN_LOAD  = TW'(MIN_ON_CYC - 1);
  localparam logic [TW-1:0]     DEAD_LOAD = TW'(DEAD_CYC - 1);
  localparam logic [PW-1:0]     PRES_LOAD = PW'(PRES_HOLD_CYC);
  localparam logic [TEMP_W-1:0] HYST_V    = TEMP_W'(HYST);

  state_t            state_q;
  logic [TW-1:0]     timer_q;
  logic [PW-1:0]     pres_cnt_q;
  logic [TEMP_W-1:0] on_th;
  logic              pres_held;
  logic              heat_want;
  logic              heat_stop;
  logic              cool_want;
  logic              timer_zero;

  // Turn-on threshold clamps at zero so a tiny setpoint never heats.
  assign on_th      = (setpoint > HYST_V) ? (setpoint - HYST_V) : '0;
  assign pres_held  = presence | (pres_cnt_q != '0);
  assign heat_want  = pres_held & ~window & (temp < on_th);
  assign heat_stop  = (temp >= setpoint) | ~pres_held;
  assign cool_want  = cool_req & ~window;
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pres_cnt_q <= '0;
    end else begin
      if (presence)
        pres_cnt_q <= PRES_LOAD;
      else if (pres_cnt_q != '0)
        pres_cnt_q <= pres_cnt_q - PW'(1);

      if (!timer_zero)
        timer_q <= timer_q - TW'(1);

      case (state_q)
        S_IDLE: begin
          if (window) begin
            state_q <= S_LOCK;
          end else if (cool_want) begin
            state_q <= S_COOL;
            timer_q <= RUN_LOAD;
          end else if (heat_want) begin
            state_q <= S_HEAT;
            timer_q <= RUN_LOAD;
          end
        end
        S_HEAT: begin
          if (window) begin
            state_q <= S_LOCK;
          end else if (timer_zero && (heat_stop || cool_want)) begin
            state_q <= S_DEAD;
            timer_q <= DEAD_LOAD;
          end
        end
        S_COOL: begin
          if (window) begin
            state_q <= S_LOCK;
          end else if (timer_zero && !cool_req) begin
            state_q <= S_DEAD;
            timer_q <= DEAD_LOAD;
          end
        end
        S_DEAD: begin
          if (window)
            state_q <= S_LOCK;
          else if (timer_zero)
            state_q <= S_IDLE;
        end
        S_LOCK: begin
          // Closing the window still pays the dead time before any new run.
          if (!window) begin
            state_q <= S_DEAD;
            timer_q <= DEAD_LOAD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign heat_en = (state_q == S_HEAT);
  assign cool_en = (state_q == S_COOL);
  assign lockout = (state_q == S_LOCK);
  assign state   = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Bench for hvac_sequencer: directed scenarios plus random traffic, scored
// against a cycle-count reference model through an expected-output queue.
module tb_hvac_sequencer;

  localparam int TEMP_W        = 8;
  localparam int HYST          = 2;
  localparam int MIN_ON_CYC    = 4;
  localparam int DEAD_CYC      = 3;
  localparam int PRES_HOLD_CYC = 5;

  localparam int M_IDLE = 0;
  localparam int M_HEAT = 1;
  localparam int M_COOL = 2;
  localparam int M_DEAD = 3;
  localparam int M_LOCK = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [TEMP_W-1:0] temp;
  logic [TEMP_W-1:0] setpoint;
  logic              presence;
  logic              window;
  logic              cool_req;
  logic              heat_en;
  logic              cool_en;
  logic              lockout;
  logic [2:0]        state;

  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  hvac_sequencer #(
    .TEMP_W(TEMP_W), .HYST(HYST), .MIN_ON_CYC(MIN_ON_CYC),
    .DEAD_CYC(DEAD_CYC), .PRES_HOLD_CYC(PRES_HOLD_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .temp(temp), .setpoint(setpoint),
    .presence(presence), .window(window), .cool_req(cool_req),
    .heat_en(heat_en), .cool_en(cool_en), .lockout(lockout), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks the mode plus how long it has lasted and how
  // long ago presence was last seen, and derives every decision from those.
  int m_mode  = M_IDLE;
  int m_age   = 0;
  int m_since = 1000;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_age   = 0;
      m_since = 1000;
    end else begin
      int  th;
      int  nxt;
      bit  held, hw, cw, hstop;
      held  = presence || (m_since <= PRES_HOLD_CYC);
      th    = int'(setpoint) - HYST;
      hw    = held && !window && (int'(temp) < th);
      cw    = cool_req && !window;
      hstop = (temp >= setpoint) || !held;
      nxt   = m_mode;
      if (window) nxt = M_LOCK;
      else begin
        case (m_mode)
          M_IDLE: nxt = cw ? M_COOL : (hw ? M_HEAT : M_IDLE);
          M_HEAT: if (m_age >= MIN_ON_CYC && (hstop || cw)) nxt = M_DEAD;
          M_COOL: if (m_age >= MIN_ON_CYC && !cool_req) nxt = M_DEAD;
          M_DEAD: if (m_age >= DEAD_CYC) nxt = M_IDLE;
          default: nxt = M_DEAD;
        endcase
      end
      m_age   = (nxt != m_mode) ? 1 : m_age + 1;
      m_mode  = nxt;
      m_since = presence ? 1 : ((m_since < 1000) ? m_since + 1 : 1000);
      exp_q.push_back({3'(m_mode), m_mode == M_HEAT, m_mode == M_COOL, m_mode == M_LOCK});
    end
  end

  // Monitor: one output word per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_outputs", {state, heat_en, cool_en, lockout}, 6'b000000);
    end else if (exp_q.size() > 0) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      check("outputs", {state, heat_en, cool_en, lockout}, e);
    end
    check("exclusive_enables", heat_en & cool_en, 0);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_cool", cool_en, 0);
    check("async_rst_heat", heat_en, 0);
    check("async_rst_state", state, 0);
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; temp = 8'd25; setpoint = 8'd20;
    presence = 1'b0; window = 1'b0; cool_req = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // basic heating run, stop condition during the minimum-on time
    presence = 1'b1; temp = 8'd17;
    tick(2);
    temp = 8'd20;
    tick(10);

    // hysteresis boundary and clamped threshold
    temp = 8'd18; tick(4);
    temp = 8'd17; tick(3);
    temp = 8'd25; tick(10);
    setpoint = 8'd2; temp = 8'd0; tick(6);
    setpoint = 8'd20; temp = 8'd25; tick(3);

    // window during the first HEAT cycle
    temp = 8'd17; tick(1);
    window = 1'b1; tick(3);
    window = 1'b0; temp = 8'd25; tick(8);

    // cooling beats heating when both appear together
    temp = 8'd10; presence = 1'b1; cool_req = 1'b1; tick(4);
    cool_req = 1'b0; tick(12);
    temp = 8'd25; tick(10);

    // presence glitches: 4-cycle drop keeps heating, 6-cycle drop stops it
    temp = 8'd17; tick(2);
    temp = 8'd19; presence = 1'b0; tick(4);
    presence = 1'b1; tick(2);
    presence = 1'b0; tick(6);
    presence = 1'b1; temp = 8'd25; tick(10);

    // asynchronous reset in the 2nd COOL cycle
    presence = 1'b0; cool_req = 1'b1; tick(1);
    async_reset_pulse();
    tick(3);
    cool_req = 1'b0; tick(10);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) window = ~window;
      if ($urandom_range(0, 7) == 0) cool_req = ~cool_req;
      if ($urandom_range(0, 5) == 0) presence = ~presence;
      if ($urandom_range(0, 3) == 0) temp = 8'($urandom_range(0, 30));
      if ($urandom_range(0, 99) == 0) setpoint = 8'($urandom_range(0, 28));
      tick(1);
    end

    window = 1'b0; cool_req = 1'b0;
    tick(3);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hvac_sequencer.md
# hvac_sequencer

Sequencing controller that owns the shared heating/cooling plant. It decides cycle by cycle whether the heater or the AC compressor is driven, and guarantees:
- they are never on together;
- each run lasts a minimum time;
- a dead-time gap separates any two runs;
- an open window forces an immediate shutdown.

It sits between the room sensor inputs (temperature, motion, window) plus the user cooling request, and the heater/AC enable outputs.

## Interface
Parameters:
- TEMP_W, 8, width of temperature and setpoint (unsigned).
- HYST, 2, heating turn-on hysteresis in temperature LSBs.
- MIN_ON_CYC, 4, minimum cycles heat_en/cool_en stays high once asserted (≥1).
- DEAD_CYC, 3, cycles both enables are forced low between runs (≥1).
- PRES_HOLD_CYC, 5, cycles presence is held after the motion input drops (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- temp  in  TEMP_W  current room temperature, synchronous to clk.
- setpoint  in  TEMP_W  target temperature.
- presence  in  1  motion sensor, high = occupant detected.
- window  in  1  high = window open.
- cool_req  in  1  user/AC cooling request.
- heat_en  out  1  heater drive.
- cool_en  out  1  AC compressor drive.
- lockout  out  1  high while in LOCK.
- state  out  3  current state code for status/debug.

## Operation
- State codes: IDLE=0, HEAT=1, COOL=2, DEAD=3, LOCK=4.
- Outputs are decoded from the state register:
  - heat_en = (state==HEAT).
  - cool_en = (state==COOL).
  - lockout = (state==LOCK).
- Presence hold counter:
  - presence=1 reloads it to PRES_HOLD_CYC; otherwise it decrements, saturating at 0.
  - pres_held = presence | (counter != 0).
- Derived conditions:
  - on_th = (setpoint > HYST) ? setpoint − HYST : 0, computed unsigned with no wrap. If setpoint ≤ HYST, heating never starts.
  - heat_want = pres_held & ~window & (temp < on_th).
  - heat_stop = (temp ≥ setpoint) | ~pres_held.
  - cool_want = cool_req & ~window.
- Run timer:
  - Loaded with MIN_ON_CYC−1 on entry to HEAT/COOL, and with DEAD_CYC−1 on entry to DEAD.
  - Decrements each cycle, saturating at 0.
  - Width is $clog2(max(MIN_ON_CYC, DEAD_CYC)+1).
- Transitions, listed in priority order within each state:
  - IDLE:
    - window → LOCK.
    - Else cool_want → COOL. Cooling wins when both are wanted.
    - Else heat_want → HEAT.
    - Else stay in IDLE.
  - HEAT:
    - window → LOCK immediately, ignoring the timer.
    - Else if timer==0 and (heat_stop | cool_want) → DEAD.
    - Else stay in HEAT.
  - COOL:
    - window → LOCK immediately.
    - Else if timer==0 and ~cool_req → DEAD.
    - Else stay in COOL.
  - DEAD:
    - window → LOCK.
    - Else if timer==0 → IDLE.
    - Else stay in DEAD.
  - LOCK:
    - ~window → DEAD, so the dead time applies after the window closes.
    - Else stay in LOCK.
- Direct HEAT↔COOL transitions are illegal; every change of direction passes through DEAD and IDLE.
- Unused state codes 5–7 return to IDLE on the next clock with both enables low.

## Timing
- Reset (rst_n=0), asynchronous:
  - state=IDLE; heat_en=0, cool_en=0, lockout=0; timer=0; presence counter=0.
  - Applies immediately, even mid-run.
  - Released synchronously on the first clk edge with rst_n=1.
- Latency: inputs are sampled on a clk edge, and state and outputs update at that same edge. A response is therefore visible 1 cycle after the input changes.
- Run length and off gap:
  - Minimum enable pulse is exactly MIN_ON_CYC cycles, unless a window event forces LOCK earlier.
  - Minimum gap between two runs is DEAD_CYC+1 cycles: DEAD_CYC cycles in DEAD plus 1 cycle in IDLE.
- heat_en and cool_en are never both high on any cycle, including across reset and illegal states.
- Simultaneous events:
  - window has priority over everything.
  - cool_want beats heat_want in IDLE.
  - A stop condition together with window in HEAT → LOCK, not DEAD.
- Presence glitches shorter than PRES_HOLD_CYC do not stop heating.

## Test plan
Parameters for all scenarios are the defaults, with setpoint=20.

- Heating run, basic: reset, presence=1, window=0, temp=17 → heat_en rises 1 cycle later. Set temp=20 on the 2nd HEAT cycle → heat_en stays high for exactly 4 cycles, then is low for 3 DEAD cycles and 1 IDLE cycle.
- Hysteresis boundary: temp=18 → no heating, since on_th=18. temp=17 → heating. setpoint=2 with temp=0 → never heats.
- Window safety: mid-HEAT on its 1st cycle, raise window → heat_en=0 and lockout=1 the next cycle. Drop window → 3 DEAD cycles, then IDLE.
- Arbitration: in IDLE, raise cool_req=1 with temp=10 and presence=1 simultaneously → COOL. Drop cool_req after 4 cycles → DEAD for 3 cycles, IDLE, then HEAT. Enables never overlap.
- Presence hold: presence drops for 4 cycles during HEAT → heating continues. Presence drops for 6 cycles → the stop condition takes effect, DEAD.
- Async reset during COOL on its 2nd cycle: rst_n=0 between edges → cool_en=0 immediately. After release → IDLE, re-entering COOL 1 cycle later if cool_req is still high.
